// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset CPU control path:
// FSM state encoding, opcode/funct constants, ALU and mux select encodings.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXE    = 4'd10,
        S_I_WB     = 4'd11,
        S_HALT     = 4'd12
    } state_e;

    // Which ALU operation the current state asks for; FUNCT defers to IR[5:0].
    typedef enum logic [1:0] {
        ALU_CLS_NONE  = 2'd0,
        ALU_CLS_ADD   = 2'd1,
        ALU_CLS_SUB   = 2'd2,
        ALU_CLS_FUNCT = 2'd3
    } alu_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/alu_decoder.sv
// Maps the state's ALU operation class and the R-type funct field to an
// alu_ctrl code; flags funct values outside the supported set.
module alu_decoder
    import cpu_pkg::*;
(
    input  alu_class_e  alu_class_i,
    input  logic [5:0]  funct_i,
    output logic [3:0]  alu_ctrl_o,
    output logic        funct_illegal_o
);

    always_comb begin
        alu_ctrl_o      = ALU_AND;
        funct_illegal_o = 1'b0;
        case (alu_class_i)
            ALU_CLS_ADD: alu_ctrl_o = ALU_ADD;
            ALU_CLS_SUB: alu_ctrl_o = ALU_SUB;
            ALU_CLS_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: funct_illegal_o = 1'b1;
                endcase
            end
            default: alu_ctrl_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS-subset CPU.
// Define MULTI_CYCLE_CTRL_BNE_EN to decode bne (opcode 0x05) as a branch.
module multi_cycle_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       halted,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    alu_class_e alu_cls;
    logic       funct_illegal;

    alu_decoder u_alu_decoder (
        .alu_class_i     (alu_cls),
        .funct_i         (funct),
        .alu_ctrl_o      (alu_ctrl),
        .funct_illegal_o (funct_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign state = state_q;

    // Kept apart from the main decode so the decoder's illegal flag never
    // loops back into the block that selects its input.
    always_comb begin
        alu_cls = ALU_CLS_NONE;
        if (rst) begin
            alu_cls = ALU_CLS_ADD;
        end else begin
            case (state_q)
                S_FETCH, S_DECODE, S_MEM_ADDR, S_I_EXE: alu_cls = ALU_CLS_ADD;
                S_BRANCH: alu_cls = ALU_CLS_SUB;
                S_R_EXE:  alu_cls = ALU_CLS_FUNCT;
                default:  alu_cls = ALU_CLS_NONE;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_en     = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTI_CYCLE_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXE;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_R_EXE: begin
                alu_src_a = 1'b1;
                state_d   = funct_illegal ? S_HALT : S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                // Only bne reaches here with OP_BNE, so beq keeps the plain sense.
                alu_src_a  = 1'b1;
                pc_src     = PCSRC_ALUOUT;
                pc_en      = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_I_EXE: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_HALT;
        endcase

        // Reset abandons the instruction: no side effects, FETCH-style selects.
        if (rst) begin
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_FOUR;
            pc_src     = PCSRC_ALU;
            instr_done = 1'b0;
            halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized instruction-stream bench for multi_cycle_ctrl: every cycle's
// outputs are compared with a step-list model of each instruction.
module tb_multi_cycle_ctrl;

  localparam int FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4;
  localparam int MEM_WR = 5, R_EXE = 6, R_WB = 7, BRANCH = 8, JUMP = 9;
  localparam int I_EXE = 10, I_WB = 11, HALT = 12;
  localparam int W = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic alu_zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic reg_write, alu_src_a, instr_done, halted;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_ctrl, state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int done_seen = 0;
  int retired = 0;

  multi_cycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .pc_src(pc_src), .instr_done(instr_done),
    .halted(halted), .state(state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  wire [W-1:0] act_vec = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                          mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl,
                          pc_src, instr_done, halted, state};

  function automatic bit funct_legal(logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
  endfunction

  // Output table straight from the per-step description of each state.
  function automatic logic [W-1:0] model_out(int st, logic [5:0] op, logic [5:0] fn,
                                             logic mr, logic az, logic r);
    logic pe, io, mrd, mwr, irw, rd, m2r, rw, sa, done, hl;
    logic [1:0] sb, ps;
    logic [3:0] ac, s4;
    {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, done, hl} = '0;
    sb = 2'd0; ps = 2'd0; ac = 4'd0;
    s4 = st[3:0];
    if (r) begin
      sb = 2'd1; ac = 4'd2;
    end else begin
      case (st)
        FETCH:    begin mrd = 1; sb = 2'd1; ac = 4'd2; pe = mr; irw = mr; end
        DECODE:   begin sb = 2'd3; ac = 4'd2; end
        MEM_ADDR: begin sa = 1; sb = 2'd2; ac = 4'd2; end
        MEM_RD:   begin io = 1; mrd = 1; end
        MEM_WB:   begin rw = 1; m2r = 1; done = 1; end
        MEM_WR:   begin io = 1; mwr = 1; done = mr; end
        R_EXE: begin
          sa = 1;
          case (fn)
            6'h20: ac = 4'd2;
            6'h22: ac = 4'd6;
            6'h24: ac = 4'd0;
            6'h25: ac = 4'd1;
            6'h2A: ac = 4'd7;
            default: ac = 4'd0;
          endcase
        end
        R_WB:     begin rw = 1; rd = 1; done = 1; end
        BRANCH:   begin sa = 1; ac = 4'd6; ps = 2'd1; pe = (op == 6'h05) ? ~az : az; done = 1; end
        JUMP:     begin ps = 2'd2; pe = 1; done = 1; end
        I_EXE:    begin sa = 1; sb = 2'd2; ac = 4'd2; end
        I_WB:     begin rw = 1; done = 1; end
        default:  hl = 1;
      endcase
    end
    return {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ac, ps, done, hl, s4};
  endfunction

  // scoreboard: one compare per driven cycle, away from the active edge
  always @(negedge clk) begin
    if (instr_done === 1'b1) done_seen++;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act_vec !== e) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual=%b required=%b", $time, act_vec, e);
      end
    end
  end

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // driver tasks
  task automatic drive_cycle(input int st, input logic mr, input logic az, input logic r);
    mem_ready = mr;
    alu_zero = az;
    rst = r;
    exp_q.push_back(model_out(st, opcode, funct, mr, az, r));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // az_mode: 0/1 forces alu_zero in BRANCH, -1 leaves it random.
  // cycles returns the instruction length, or -1 if it halted.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall,
                           input int mstall, input int az_mode, output int cycles);
    int seq[$];
    logic az;
    case (op)
      6'h23: seq = '{FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB};
      6'h2B: seq = '{FETCH, DECODE, MEM_ADDR, MEM_WR};
      6'h00: if (funct_legal(fn)) seq = '{FETCH, DECODE, R_EXE, R_WB};
             else seq = '{FETCH, DECODE, R_EXE, HALT};
      6'h04: seq = '{FETCH, DECODE, BRANCH};
`ifdef MULTI_CYCLE_CTRL_BNE_EN
      6'h05: seq = '{FETCH, DECODE, BRANCH};
`endif
      6'h02: seq = '{FETCH, DECODE, JUMP};
      6'h08: seq = '{FETCH, DECODE, I_EXE, I_WB};
      default: seq = '{FETCH, DECODE, HALT};
    endcase
    opcode = op;
    funct = fn;
    cycles = 0;
    foreach (seq[i]) begin
      if (seq[i] == HALT) begin
        for (int k = 0; k < 20; k++) drive_cycle(HALT, rbit(), rbit(), 1'b0);
        drive_cycle(HALT, rbit(), rbit(), 1'b1);
        cycles = -1;
        break;
      end else if (seq[i] == FETCH || seq[i] == MEM_RD || seq[i] == MEM_WR) begin
        int n = (seq[i] == FETCH) ? fstall : mstall;
        for (int k = 0; k < n; k++) begin
          drive_cycle(seq[i], 1'b0, rbit(), 1'b0);
          cycles++;
        end
        drive_cycle(seq[i], 1'b1, rbit(), 1'b0);
        cycles++;
      end else begin
        az = (seq[i] == BRANCH && az_mode >= 0) ? 1'(az_mode) : rbit();
        drive_cycle(seq[i], rbit(), az, 1'b0);
        cycles++;
      end
    end
    if (cycles > 0) retired++;
  endtask

  logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    int cyc;
    int k;
    logic [5:0] op, fn;
    @(posedge clk);
    #1;
    drive_cycle(FETCH, 1'b1, 1'b0, 1'b1);

    run_instr(6'h00, 6'h20, 0, 0, -1, cyc);  check_int("add_cycles", cyc, 4);
    run_instr(6'h23, 6'h00, 0, 2, -1, cyc);  check_int("lw_stall2_cycles", cyc, 7);
    run_instr(6'h2B, 6'h11, 0, 0, -1, cyc);  check_int("sw_cycles", cyc, 4);
    run_instr(6'h08, 6'h3F, 0, 0, -1, cyc);  check_int("addi_cycles", cyc, 4);
    run_instr(6'h04, 6'h00, 0, 0, 1, cyc);   check_int("beq_taken_cycles", cyc, 3);
    run_instr(6'h04, 6'h00, 0, 0, 0, cyc);   check_int("beq_not_taken_cycles", cyc, 3);
    run_instr(6'h02, 6'h00, 0, 0, -1, cyc);  check_int("j_cycles", cyc, 3);
    run_instr(6'h00, 6'h2A, 1, 0, -1, cyc);  check_int("slt_fetch_stall_cycles", cyc, 5);
    run_instr(6'h3F, 6'h00, 0, 0, -1, cyc);  check_int("illegal_op_halts", cyc, -1);
    run_instr(6'h00, 6'h01, 0, 0, -1, cyc);  check_int("illegal_funct_halts", cyc, -1);
`ifdef MULTI_CYCLE_CTRL_BNE_EN
    run_instr(6'h05, 6'h00, 0, 0, 0, cyc);   check_int("bne_taken_cycles", cyc, 3);
    run_instr(6'h05, 6'h00, 0, 0, 1, cyc);   check_int("bne_not_taken_cycles", cyc, 3);
`else
    run_instr(6'h05, 6'h00, 0, 0, 0, cyc);   check_int("bne_disabled_halts", cyc, -1);
`endif

    // sw abandoned by reset while the write is completing
    opcode = 6'h2B;
    drive_cycle(FETCH, 1'b1, 1'b0, 1'b0);
    drive_cycle(DECODE, 1'b1, 1'b0, 1'b0);
    drive_cycle(MEM_ADDR, 1'b1, 1'b0, 1'b0);
    drive_cycle(MEM_WR, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 19);
      fn = 6'($urandom_range(0, 63));
      if (k <= 5) begin op = 6'h00; fn = legal_fn[$urandom_range(0, 4)]; end
      else if (k <= 8) op = 6'h23;
      else if (k <= 10) op = 6'h2B;
      else if (k <= 12) op = 6'h04;
      else if (k == 13 || k == 19) op = 6'h02;
      else if (k <= 15) op = 6'h08;
      else if (k == 16) op = 6'h05;
      else if (k == 17) begin op = 6'h00; fn = 6'($urandom_range(0, 31)); end
      else op = 6'($urandom_range(6'h30, 6'h3F));
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3), -1, cyc);
    end

    @(negedge clk);
    check_int("instr_done_pulses", done_seen, retired);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
